ahb_matrix_rr: RTL

Parametrised successor to the fixed 4-master/4-slave shared AHB bus. It combines a round-robin arbiter, an address decoder with a built-in default slave, and address-phase and data-phase multiplexers, all in one block.
- Master and slave counts, data width and decode field are parameters.
- Fixed-length bursts cannot be broken by arbitration.
- The data-phase select is registered, so the pipelined AHB address/data overlap is correct.
- It sits between the master BFMs/encoders and the slave models.

---
 rtl/ahb_matrix_rr.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_matrix_rr.sv
// ahb_matrix_rr: parametrised shared AHB bus with round-robin arbitration,
// address decode with a built-in default slave, and address/data-phase
// multiplexing. The data-phase select is registered on hready so that the
// pipelined address/data overlap is steered to the correct slave and master.
module ahb_matrix_rr #(
    parameter int unsigned NM      = 4,
    parameter int unsigned NS      = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SEL_LSB = 28,
    parameter int unsigned SEL_W   = 4
) (
    input  logic                    clk,
    input  logic                    hrst,
    input  logic [NM-1:0]           m_hbusreq,
    input  logic [NM*AW-1:0]        m_haddr,
    input  logic [NM*2-1:0]         m_htrans,
    input  logic [NM-1:0]           m_hwrite,
    input  logic [NM*3-1:0]         m_hsize,
    input  logic [NM*3-1:0]         m_hburst,
    input  logic [NM*DW-1:0]        m_hwdata,
    output logic [NM-1:0]           m_hgrant,
    output logic [$clog2(NM)-1:0]   hmaster,
    output logic                    hready,
    output logic [1:0]              hresp,
    output logic [DW-1:0]           hrdata,
    output logic [NS-1:0]           s_hsel,
    output logic [AW-1:0]           s_haddr,
    output logic [1:0]              s_htrans,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [2:0]              s_hburst,
    output logic [DW-1:0]           s_hwdata,
    input  logic [NS*DW-1:0]        s_hrdata,
    input  logic [NS-1:0]           s_hreadyout,
    input  logic [NS*2-1:0]         s_hresp
);

    localparam int unsigned MW = $clog2(NM);

    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [1:0] HR_OKAY   = 2'b00;
    localparam logic [1:0] HR_ERROR  = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_t;

    typedef enum logic [1:0] {
        DP_NONE,
        DP_SLV,
        DP_DEF
    } dp_kind_t;

    // Address-phase ownership and fixed-burst tracking
    logic [MW-1:0]    hmaster_q;
    logic [3:0]       blft;
    logic [3:0]       blft_next;
    logic [MW-1:0]    arb_next;
    logic             arb_found;

    // Data-phase select
    dp_kind_t         dkind;
    dp_kind_t         dkind_next;
    logic [SEL_W-1:0] didx;
    logic [MW-1:0]    dmaster;

    // Decode of the current address phase
    logic [SEL_W-1:0] sel_idx;
    logic             sel_mapped;

    // Default slave
    ds_state_t        ds_state;
    ds_state_t        ds_next;
    logic             ds_hready;
    logic [1:0]       ds_hresp;

    assign hmaster = hmaster_q;

    // One-hot grant follows the registered owner directly
    always_comb begin
        m_hgrant = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            m_hgrant[i] = (hmaster_q == MW'(i));
        end
    end

    // Address-phase mux: owner's control and address go straight to the slaves
    always_comb begin
        s_haddr  = '0;
        s_htrans = '0;
        s_hwrite = 1'b0;
        s_hsize  = '0;
        s_hburst = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (hmaster_q == MW'(i)) begin
                s_haddr  = m_haddr[i*AW +: AW];
                s_htrans = m_htrans[i*2 +: 2];
                s_hwrite = m_hwrite[i];
                s_hsize  = m_hsize[i*3 +: 3];
                s_hburst = m_hburst[i*3 +: 3];
            end
        end
    end

    // Address decode; an index beyond the slave count falls to the default slave
    always_comb begin
        sel_idx    = s_haddr[SEL_LSB +: SEL_W];
        sel_mapped = (32'(sel_idx) < NS);
        s_hsel     = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            s_hsel[i] = (sel_idx == SEL_W'(i));
        end
    end

    // Kind of data phase that follows the current address phase
    always_comb begin
        if (!s_htrans[1]) begin
            dkind_next = DP_NONE;
        end else if (sel_mapped) begin
            dkind_next = DP_SLV;
        end else begin
            dkind_next = DP_DEF;
        end
    end

    // Data-phase mux: response/read data from the selected slave, write data
    // from the master that owned the matching address phase
    always_comb begin
        hready   = 1'b1;
        hresp    = HR_OKAY;
        hrdata   = '0;
        s_hwdata = '0;
        case (dkind)
            DP_SLV: begin
                for (int unsigned i = 0; i < NS; i++) begin
                    if (didx == SEL_W'(i)) begin
                        hready = s_hreadyout[i];
                        hresp  = s_hresp[i*2 +: 2];
                        hrdata = s_hrdata[i*DW +: DW];
                    end
                end
            end
            DP_DEF: begin
                hready = ds_hready;
                hresp  = ds_hresp;
            end
            default: ;
        endcase
        if (dkind != DP_NONE) begin
            for (int unsigned i = 0; i < NM; i++) begin
                if (dmaster == MW'(i)) begin
                    s_hwdata = m_hwdata[i*DW +: DW];
                end
            end
        end
    end

    // Remaining beats of a fixed-length burst; arbitration waits for zero
    always_comb begin
        blft_next = blft;
        if (hready) begin
            if (s_htrans == HT_NONSEQ) begin
                case (s_hburst)
                    3'b010, 3'b011: blft_next = 4'd3;
                    3'b100, 3'b101: blft_next = 4'd7;
                    3'b110, 3'b111: blft_next = 4'd15;
                    default:        blft_next = 4'd0;
                endcase
            end else if (s_htrans == HT_SEQ && blft != '0) begin
                blft_next = blft - 4'd1;
            end
        end else if (hresp == HR_ERROR) begin
            blft_next = '0;
        end
    end

    // Round-robin pick: masters above the owner first, then wrap to the owner
    always_comb begin
        arb_next  = '0;
        arb_found = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (!arb_found && m_hbusreq[i] && (i > 32'(hmaster_q))) begin
                arb_found = 1'b1;
                arb_next  = MW'(i);
            end
        end
        for (int unsigned i = 0; i < NM; i++) begin
            if (!arb_found && m_hbusreq[i] && (i <= 32'(hmaster_q))) begin
                arb_found = 1'b1;
                arb_next  = MW'(i);
            end
        end
    end

    // Ownership, burst count and data-phase select; frozen during wait states
    always_ff @(posedge clk) begin
        if (!hrst) begin
            hmaster_q <= '0;
            blft      <= '0;
            dkind     <= DP_NONE;
            didx      <= '0;
            dmaster   <= '0;
        end else begin
            blft <= blft_next;
            if (hready) begin
                dkind   <= dkind_next;
                didx    <= sel_idx;
                dmaster <= hmaster_q;
                if (blft_next == '0) begin
                    hmaster_q <= arb_next;
                end
            end
        end
    end

    // Default-slave state register
    always_ff @(posedge clk) begin
        if (!hrst) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    // Default-slave next state: two-cycle ERROR for each accepted unmapped transfer
    always_comb begin
        ds_next = ds_state;
        if (hready && s_htrans[1] && !sel_mapped) begin
            ds_next = DS_ERR1;
        end else begin
            case (ds_state)
                DS_ERR1: ds_next = DS_ERR2;
                DS_ERR2: ds_next = DS_IDLE;
                default: ds_next = DS_IDLE;
            endcase
        end
    end

    // Default-slave response outputs
    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = HR_OKAY;
        case (ds_state)
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HR_ERROR;
            end
            DS_ERR2: begin
                ds_hready = 1'b1;
                ds_hresp  = HR_ERROR;
            end
            default: ;
        endcase
    end

endmodule
